score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/pong_pkg.sv | 20 ++
 rtl/serve_timer.sv | 24 ++
 rtl/score_keeper.sv | 105 ++++++++++
 tb/tb_score_keeper.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared score width, score ceiling and FSM state encoding.
// The score display decoder imports ScoreWidth from here so both sides agree.
package pong_pkg;

    localparam int ScoreWidth = 7;
    localparam int MaxScore   = 99;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE    = 2'd1,
        PLAY     = 2'd2,
        GAMEOVER = 2'd3
    } state_e;

    // Adds one point but holds at MaxScore so the display never wraps to 0.
    function automatic logic [ScoreWidth-1:0] sat_inc(input logic [ScoreWidth-1:0] s);
        return (s >= ScoreWidth'(MaxScore)) ? s : s + 1'b1;
    endfunction

endpackage

// File: rtl/serve_timer.sv
// serve_timer: counts frame ticks while enabled; done fires on the tick that
// brings the count to ServeFrames, so the caller can leave SERVE on that edge.
module serve_timer #(
    parameter int ServeFrames = 60
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic done_o
);

    logic [7:0] count_q, count_d;

    always_comb count_d = clear_i ? 8'd0 : (enable_i ? count_q + 8'd1 : count_q);

    assign done_o = enable_i && !clear_i && (count_q == 8'(ServeFrames - 1));

    always_ff @(posedge clk) begin
        if (reset) count_q <= 8'd0;
        else       count_q <= count_d;
    end

endmodule

// File: rtl/score_keeper.sv
// score_keeper: pong game sequencer -- serve delay, point scoring, win detect.
// Every output is a flop; inputs only reach outputs through next-state logic.
module score_keeper
    import pong_pkg::*;
#(
    parameter int WinScore    = 11,
    parameter int ServeFrames = 60
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frameTick,
    input  logic                  start,
    input  logic                  pointLeft,
    input  logic                  pointRight,
    output logic [ScoreWidth-1:0] scoreLeft,
    output logic [ScoreWidth-1:0] scoreRight,
    output logic                  ballEnable,
    output logic                  serveDir,
    output logic                  gameOver,
    output logic                  winner
);

    localparam logic [ScoreWidth-1:0] WinVal = ScoreWidth'(WinScore);

    state_e                state_q, state_d;
    logic [ScoreWidth-1:0] left_q, left_d, right_q, right_d;
    logic [ScoreWidth-1:0] left_inc, right_inc;
    logic                  dir_q, dir_d, win_q, win_d, ball_q, over_q;
    logic                  serve_done;

    // Counter is held clear outside SERVE, so it always starts from 0 on entry.
    serve_timer #(.ServeFrames(ServeFrames)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (state_q != SERVE),
        .enable_i (frameTick),
        .done_o   (serve_done)
    );

    assign left_inc  = sat_inc(left_q);
    assign right_inc = sat_inc(right_q);

    always_comb begin
        state_d = state_q;
        left_d  = left_q;
        right_d = right_q;
        dir_d   = dir_q;
        win_d   = win_q;
        unique case (state_q)
            IDLE:  state_d = start ? SERVE : IDLE;
            SERVE: state_d = serve_done ? PLAY : SERVE;
            PLAY: begin
                if (pointLeft && pointRight) begin
                    state_d = SERVE;
                end else if (pointLeft) begin
                    left_d  = left_inc;
                    dir_d   = 1'b1;
                    state_d = (left_inc == WinVal) ? GAMEOVER : SERVE;
                    win_d   = (left_inc == WinVal) ? 1'b0 : win_q;
                end else if (pointRight) begin
                    right_d = right_inc;
                    dir_d   = 1'b0;
                    state_d = (right_inc == WinVal) ? GAMEOVER : SERVE;
                    win_d   = (right_inc == WinVal) ? 1'b1 : win_q;
                end
            end
            GAMEOVER: begin
                if (start) begin
                    left_d  = '0;
                    right_d = '0;
                    dir_d   = 1'b1;
                    state_d = SERVE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            left_q  <= '0;
            right_q <= '0;
            dir_q   <= 1'b1;
            win_q   <= 1'b0;
            ball_q  <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            left_q  <= left_d;
            right_q <= right_d;
            dir_q   <= dir_d;
            win_q   <= win_d;
            ball_q  <= (state_d == PLAY);
            over_q  <= (state_d == GAMEOVER);
        end
    end

    assign scoreLeft  = left_q;
    assign scoreRight = right_q;
    assign ballEnable = ball_q;
    assign serveDir   = dir_q;
    assign gameOver   = over_q;
    assign winner     = win_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: two instances (default 11/60 and 99/3) share one stimulus
// stream and are checked every cycle against a rule-level game model.
module tb_score_keeper;

    logic clk = 1'b0;
    logic reset, frameTick, start, pointLeft, pointRight;
    logic [6:0] sl [2];
    logic [6:0] sr [2];
    logic be [2];
    logic dir [2];
    logic go [2];
    logic win [2];

    int n_assert = 0;
    int n_fail   = 0;

    int wv  [2] = '{11, 99};
    int sfv [2] = '{60, 3};
    int m_st [2];
    int m_cnt [2];
    int m_l [2];
    int m_r [2];
    int m_dir [2];
    int m_win [2];

    always #5 clk = ~clk;

    score_keeper #(.WinScore(11), .ServeFrames(60)) dut0 (
        .clk(clk), .reset(reset), .frameTick(frameTick), .start(start),
        .pointLeft(pointLeft), .pointRight(pointRight),
        .scoreLeft(sl[0]), .scoreRight(sr[0]), .ballEnable(be[0]),
        .serveDir(dir[0]), .gameOver(go[0]), .winner(win[0])
    );

    score_keeper #(.WinScore(99), .ServeFrames(3)) dut1 (
        .clk(clk), .reset(reset), .frameTick(frameTick), .start(start),
        .pointLeft(pointLeft), .pointRight(pointRight),
        .scoreLeft(sl[1]), .scoreRight(sr[1]), .ballEnable(be[1]),
        .serveDir(dir[1]), .gameOver(go[1]), .winner(win[1])
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model states: 0 idle, 1 serve, 2 play, 3 game over.
    task automatic model(input int d, input bit rs, input bit fr, input bit st,
                         input bit pl, input bit pr);
        int s;
        if (rs) begin
            m_st[d] = 0; m_cnt[d] = 0; m_l[d] = 0; m_r[d] = 0; m_dir[d] = 1; m_win[d] = 0;
            return;
        end
        case (m_st[d])
            0: if (st) begin m_st[d] = 1; m_cnt[d] = 0; end
            1: if (fr) begin
                m_cnt[d]++;
                if (m_cnt[d] == sfv[d]) m_st[d] = 2;
            end
            2: if (pl && pr) begin
                m_st[d] = 1; m_cnt[d] = 0;
            end else if (pl || pr) begin
                if (pl) begin m_l[d] = (m_l[d] < 99) ? m_l[d] + 1 : 99; s = m_l[d]; m_dir[d] = 1; end
                else    begin m_r[d] = (m_r[d] < 99) ? m_r[d] + 1 : 99; s = m_r[d]; m_dir[d] = 0; end
                if (s == wv[d]) begin m_st[d] = 3; m_win[d] = pr ? 1 : 0; end
                else begin m_st[d] = 1; m_cnt[d] = 0; end
            end
            default: if (st) begin
                m_l[d] = 0; m_r[d] = 0; m_dir[d] = 1; m_st[d] = 1; m_cnt[d] = 0;
            end
        endcase
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d scoreLeft", d),  {1'b0, sl[d]}, 8'(m_l[d]));
            chk($sformatf("d%0d scoreRight", d), {1'b0, sr[d]}, 8'(m_r[d]));
            chk($sformatf("d%0d ballEnable", d), {7'd0, be[d]}, {7'd0, m_st[d] == 2});
            chk($sformatf("d%0d serveDir", d),   {7'd0, dir[d]}, 8'(m_dir[d]));
            chk($sformatf("d%0d gameOver", d),   {7'd0, go[d]}, {7'd0, m_st[d] == 3});
            chk($sformatf("d%0d winner", d),     {7'd0, win[d]}, 8'(m_win[d]));
        end
    endtask

    task automatic step(input bit rs, input bit fr, input bit st, input bit pl, input bit pr);
        reset = rs; frameTick = fr; start = st; pointLeft = pl; pointRight = pr;
        for (int d = 0; d < 2; d++) model(d, rs, fr, st, pl, pr);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        repeat (n) step(0, 1, 0, 0, 0);
    endtask

    task automatic serve_point(input int n, input bit pl, input bit pr);
        ticks(n);
        step(0, 0, 0, pl, pr);
    endtask

    initial begin
        reset = 1; frameTick = 0; start = 0; pointLeft = 0; pointRight = 0;
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1);
        chk("reset serveDir", {7'd0, dir[0]}, 8'd1);
        chk("reset scoreLeft", {1'b0, sl[0]}, 8'd0);
        // Start with a coincident tick on the first post-reset cycle.
        step(0, 1, 1, 0, 0);
        ticks(59);
        chk("ball before 60th tick", {7'd0, be[0]}, 8'd0);
        ticks(1);
        chk("ball after 60th tick", {7'd0, be[0]}, 8'd1);
        chk("serveDir at first serve", {7'd0, dir[0]}, 8'd1);
        step(0, 0, 0, 1, 0);
        chk("left point score", {1'b0, sl[0]}, 8'd1);
        chk("left point ball off", {7'd0, be[0]}, 8'd0);
        chk("left point dir", {7'd0, dir[0]}, 8'd1);
        serve_point(60, 0, 1);
        chk("right point score", {1'b0, sr[0]}, 8'd1);
        chk("right point dir", {7'd0, dir[0]}, 8'd0);
        repeat (2) serve_point(60, 0, 1);
        repeat (9) serve_point(60, 1, 0);
        chk("score 10", {1'b0, sl[0]}, 8'd10);
        chk("score 3", {1'b0, sr[0]}, 8'd3);
        serve_point(60, 1, 0);
        chk("win scoreLeft", {1'b0, sl[0]}, 8'd11);
        chk("win gameOver", {7'd0, go[0]}, 8'd1);
        chk("win winner", {7'd0, win[0]}, 8'd0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        ticks(5);
        chk("frozen left", {1'b0, sl[0]}, 8'd11);
        chk("frozen right", {1'b0, sr[0]}, 8'd3);
        step(0, 1, 1, 0, 0);
        chk("restart left", {1'b0, sl[0]}, 8'd0);
        chk("restart dir", {7'd0, dir[0]}, 8'd1);
        repeat (4) serve_point(60, 1, 0);
        repeat (4) serve_point(60, 0, 1);
        serve_point(60, 1, 1);
        chk("tie left", {1'b0, sl[0]}, 8'd4);
        chk("tie right", {1'b0, sr[0]}, 8'd4);
        chk("tie dir", {7'd0, dir[0]}, 8'd0);
        chk("tie ball", {7'd0, be[0]}, 8'd0);
        serve_point(10, 1, 0);
        chk("serve pulse dropped", {1'b0, sl[0]}, 8'd4);
        ticks(20);
        step(1, 1, 1, 1, 1);
        chk("midserve reset left", {1'b0, sl[0]}, 8'd0);
        chk("midserve reset ball", {7'd0, be[0]}, 8'd0);
        chk("midserve reset dir", {7'd0, dir[0]}, 8'd1);
        step(0, 0, 1, 0, 0);
        repeat (98) begin
            serve_point(3, 1, 0);
            serve_point(3, 0, 1);
        end
        chk("d1 left 98", {1'b0, sl[1]}, 8'd98);
        chk("d1 right 98", {1'b0, sr[1]}, 8'd98);
        serve_point(3, 1, 0);
        chk("d1 left 99", {1'b0, sl[1]}, 8'd99);
        chk("d1 gameOver", {7'd0, go[1]}, 8'd1);
        serve_point(3, 1, 0);
        chk("d1 no wrap", {1'b0, sl[1]}, 8'd99);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(99) == 0, $urandom_range(1) == 1, $urandom_range(29) == 0,
                 $urandom_range(9) == 0, $urandom_range(9) == 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
